game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
- Top-level round sequencer for the flappy bird game; sits directly downstream of the pipe generator.
- Consumes the pipe column, the gap row and the pass pulse, plus the bird row from bird physics.
- Detects collisions and keeps the 2-digit BCD score and the high score.
- Drives `playing` back to the pipe generator and bird physics, and drives the status outputs for the display.

Parameters:
- GAP_SIZE, 4: gap height in rows; must match the pipe generator.
- BIRD_X, 12: bird column on the 16-column grid.
- FLOOR_Y, 15: bird row treated as ground contact.
- DEATH_CYCLES, 25_000_000: cycles held in DYING before GAME_OVER (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start_btn  in  1  raw start/restart button, asynchronous to clk, active-high.
- bird_y  in  4  current bird row, 0 = top.
- pipe_x  in  4  current pipe column.
- gap_y  in  4  top row of the pipe gap.
- pipe_passed  in  1  one-cycle pulse when the pipe passes the bird.
- playing  out  1  high only in PLAYING.
- game_over  out  1  high only in GAME_OVER.
- dying  out  1  high only in DYING.
- round_start  out  1  one-cycle pulse on IDLE->PLAYING, used to restart bird and pipes.
- collision  out  1  one-cycle pulse on PLAYING->DYING.
- score_tens, score_ones  out  4 each  current score in BCD.
- high_tens, high_ones  out  4 each  high score in BCD.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0.
  - score=00, high=00, death counter=0, sync flops=0.
- Start synchronizer:
  - 3 flops s1->s2->s3; start_edge = s2 & ~s3.
  - A level rise on start_btn that is set up before clock edge N asserts start_edge after edge N+1.
  - The resulting state change takes effect at edge N+2.
  - A held button produces exactly one edge.
- Hit condition (combinational):
  - (pipe_x == BIRD_X AND (bird_y < gap_y OR bird_y >= gap_y + GAP_SIZE)) OR bird_y >= FLOOR_Y.
  - The compare gap_y + GAP_SIZE uses 5-bit arithmetic, so no wrap occurs: gap_y=12 gives 16, meaning rows 12..15 are open.
- FSM:
  - IDLE: start_edge -> PLAYING. On that same edge: score cleared to 00 and round_start=1 for one cycle.
  - PLAYING:
    - hit -> DYING; collision=1 for one cycle; death counter cleared.
    - Otherwise, pipe_passed increments the score.
  - DYING:
    - Counter increments each cycle.
    - When counter == DEATH_CYCLES-1 -> GAME_OVER, so exactly DEATH_CYCLES cycles are spent in DYING.
    - On that transition, if score > high then high <= score (BCD compare, tens first).
  - GAME_OVER: start_edge -> IDLE; score is retained until the next IDLE->PLAYING transition.
  - start_edge is ignored in PLAYING and DYING.
- Score arithmetic:
  - BCD increment: ones 9->0 with carry into tens.
  - Saturates at 99; further pipe_passed pulses leave it at 99.
- Simultaneous events:
  - hit and pipe_passed in the same PLAYING cycle: collision wins, score unchanged.
  - pipe_passed outside PLAYING is ignored.
- Status outputs are registered state decodes: playing, dying and game_over change on the same edge as the state register.
- High score survives rounds; it is cleared only by reset.
- Reset asserted mid-round forces IDLE immediately and asynchronously. Score, high score and counter clear; no round_start or collision pulse is emitted.

Test Plan:
1. Reset, then raise start_btn before edge N -> playing=1 and a one-cycle round_start after edge N+2; score=00.
2. PLAYING with bird_y=5, gap_y=3, pipe_x=12 (in gap), pulse pipe_passed 12 times -> score_tens=1, score_ones=2, collision stays 0.
3. PLAYING with pipe_x=12, gap_y=6, bird_y=10 (below gap, 6+4=10) -> collision pulse, dying=1. With DEATH_CYCLES=4: game_over=1 after exactly 4 cycles, high=12 when score was 12.
4. bird_y=15 with pipe_x=3 -> collision. Separately, gap_y=12, bird_y=14, pipe_x=12 -> no collision (no wrap).
5. Score at 99, pipe_passed pulse -> stays 99. Assert hit and pipe_passed in the same cycle at score 07 -> score stays 07, DYING entered.
6. Hold start_btn high through GAME_OVER->IDLE -> only one transition occurs. Assert reset low mid-PLAYING -> IDLE, score=00 and high=00 without waiting for a clk edge.

Source files
------------

// File: rtl/game_controller.sv
// Round sequencer for the flappy bird game: start-button synchronizer,
// collision detection, round FSM, 2-digit BCD score and high score.
module game_controller #(
    parameter int unsigned GAP_SIZE     = 4,
    parameter int unsigned BIRD_X       = 12,
    parameter int unsigned FLOOR_Y      = 15,
    parameter int unsigned DEATH_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [3:0] bird_y,
    input  logic [3:0] pipe_x,
    input  logic [3:0] gap_y,
    input  logic       pipe_passed,
    output logic       playing,
    output logic       game_over,
    output logic       dying,
    output logic       round_start,
    output logic       collision,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] high_tens,
    output logic [3:0] high_ones
);

    localparam int unsigned CW = $clog2(DEATH_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAYING,
        S_DYING,
        S_GAME_OVER
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic            start_edge;
    logic            hit;
    logic [4:0]      gap_end;
    logic [3:0]      sc_t_q, sc_t_d, sc_o_q, sc_o_d;
    logic [3:0]      hi_t_q, hi_t_d, hi_o_q, hi_o_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;
    logic            playing_q, playing_d;
    logic            dying_q, dying_d;
    logic            over_q, over_d;
    logic            rs_q, rs_d;
    logic            col_q, col_d;
    logic            score_gt_high;

    assign start_edge = s2_q & ~s3_q;

    // Gap end computed in 5 bits so a gap at the bottom rows does not wrap.
    assign gap_end = {1'b0, gap_y} + 5'(GAP_SIZE);
    assign hit = ((pipe_x == 4'(BIRD_X)) &&
                  (({1'b0, bird_y} < {1'b0, gap_y}) || ({1'b0, bird_y} >= gap_end)))
                 || (bird_y >= 4'(FLOOR_Y));

    assign score_gt_high = (sc_t_q > hi_t_q) || ((sc_t_q == hi_t_q) && (sc_o_q > hi_o_q));

    // Three-flop synchronizer for the asynchronous start button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= start_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State register, registered status decodes and round datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sc_t_q    <= '0;
            sc_o_q    <= '0;
            hi_t_q    <= '0;
            hi_o_q    <= '0;
            dcnt_q    <= '0;
            playing_q <= 1'b0;
            dying_q   <= 1'b0;
            over_q    <= 1'b0;
            rs_q      <= 1'b0;
            col_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_t_q    <= sc_t_d;
            sc_o_q    <= sc_o_d;
            hi_t_q    <= hi_t_d;
            hi_o_q    <= hi_o_d;
            dcnt_q    <= dcnt_d;
            playing_q <= playing_d;
            dying_q   <= dying_d;
            over_q    <= over_d;
            rs_q      <= rs_d;
            col_q     <= col_d;
        end
    end

    // Next-state, score/high-score update and one-cycle pulses.
    always_comb begin
        state_d = state_q;
        sc_t_d  = sc_t_q;
        sc_o_d  = sc_o_q;
        hi_t_d  = hi_t_q;
        hi_o_d  = hi_o_q;
        dcnt_d  = dcnt_q;
        rs_d    = 1'b0;
        col_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_PLAYING;
                    sc_t_d  = '0;
                    sc_o_d  = '0;
                    rs_d    = 1'b1;
                end
            end
            S_PLAYING: begin
                if (hit) begin
                    state_d = S_DYING;
                    col_d   = 1'b1;
                    dcnt_d  = '0;
                end else if (pipe_passed && !((sc_t_q == 4'd9) && (sc_o_q == 4'd9))) begin
                    if (sc_o_q == 4'd9) begin
                        sc_o_d = '0;
                        sc_t_d = sc_t_q + 4'd1;
                    end else begin
                        sc_o_d = sc_o_q + 4'd1;
                    end
                end
            end
            S_DYING: begin
                if (dcnt_q == CW'(DEATH_CYCLES - 1)) begin
                    state_d = S_GAME_OVER;
                    if (score_gt_high) begin
                        hi_t_d = sc_t_q;
                        hi_o_d = sc_o_q;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        playing_d = (state_d == S_PLAYING);
        dying_d   = (state_d == S_DYING);
        over_d    = (state_d == S_GAME_OVER);
    end

    assign playing     = playing_q;
    assign dying       = dying_q;
    assign game_over   = over_q;
    assign round_start = rs_q;
    assign collision   = col_q;
    assign score_tens  = sc_t_q;
    assign score_ones  = sc_o_q;
    assign high_tens   = hi_t_q;
    assign high_ones   = hi_o_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed round scenarios plus random play,
// checked every cycle against an integer-level model of the game rules.
module tb_game_controller;

    localparam int DEATH = 4;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic [3:0] bird_y;
    logic [3:0] pipe_x;
    logic [3:0] gap_y;
    logic       pipe_passed;
    logic       playing, game_over, dying, round_start, collision;
    logic [3:0] score_tens, score_ones, high_tens, high_ones;

    int total = 0;
    int bad   = 0;

    // Model state: round phase, integer scores, button history.
    localparam int M_IDLE = 0, M_PLAY = 1, M_DIE = 2, M_OVER = 3;
    int m_mode, m_score, m_high, m_dtime;
    bit m_rs, m_col;
    bit b1, b2, b3;

    game_controller #(
        .GAP_SIZE(4),
        .BIRD_X(12),
        .FLOOR_Y(15),
        .DEATH_CYCLES(DEATH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_btn(start_btn),
        .bird_y(bird_y),
        .pipe_x(pipe_x),
        .gap_y(gap_y),
        .pipe_passed(pipe_passed),
        .playing(playing),
        .game_over(game_over),
        .dying(dying),
        .round_start(round_start),
        .collision(collision),
        .score_tens(score_tens),
        .score_ones(score_ones),
        .high_tens(high_tens),
        .high_ones(high_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit model_hit();
        int by, gy, px;
        by = int'(bird_y);
        gy = int'(gap_y);
        px = int'(pipe_x);
        return ((px == 12) && ((by < gy) || (by >= gy + 4))) || (by >= 15);
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_score = 0;
        m_high  = 0;
        m_dtime = 0;
        m_rs    = 0;
        m_col   = 0;
        b1 = 0; b2 = 0; b3 = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit se;
        se    = b2 && !b3;
        m_rs  = 0;
        m_col = 0;
        case (m_mode)
            M_IDLE: if (se) begin
                m_mode  = M_PLAY;
                m_score = 0;
                m_rs    = 1;
            end
            M_PLAY: if (model_hit()) begin
                m_mode  = M_DIE;
                m_col   = 1;
                m_dtime = 0;
            end else if (pipe_passed) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
            end
            M_DIE: begin
                m_dtime++;
                if (m_dtime == DEATH) begin
                    m_mode = M_OVER;
                    if (m_score > m_high) m_high = m_score;
                end
            end
            default: if (se) m_mode = M_IDLE;
        endcase
        b3 = b2;
        b2 = b1;
        b1 = start_btn;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        logic [7:0] exp_st;
        exp_st = {3'b000, m_mode == M_PLAY, m_mode == M_OVER, m_mode == M_DIE, m_rs, m_col};
        chk("status", {3'b000, playing, game_over, dying, round_start, collision}, exp_st);
        chk("score", {score_tens, score_ones}, bcd(m_score));
        chk("high", {high_tens, high_ones}, bcd(m_high));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        start_btn = 1'b1;
        ticks(4);
        start_btn = 1'b0;
        ticks(4);
    endtask

    task automatic pass_n(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1;
            tick();
            pipe_passed = 1'b0;
            tick();
        end
    endtask

    task automatic safe_inputs();
        bird_y = 4'd5;
        gap_y = 4'd3;
        pipe_x = 4'd12;
        pipe_passed = 1'b0;
    endtask

    // Assert reset between clock edges and check outputs clear before any edge.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start_btn = 1'b0;
        safe_inputs();
        pipe_x = 4'd0;
        #1;
        reset = 1'b0;
        #2;
        model_reset();
        compare();
        #5;
        reset = 1'b1;

        // Start: button rises before edge N, PLAYING from edge N+2.
        ticks(2);
        start_btn = 1'b1;
        ticks(5);
        start_btn = 1'b0;
        ticks(3);

        // Twelve pipes passed with bird inside the gap.
        safe_inputs();
        pass_n(12);

        // Bird just below the gap: collision, DEATH cycles dying, high = 12.
        gap_y = 4'd6;
        bird_y = 4'd10;
        ticks(DEATH + 3);

        // Held button through GAME_OVER->IDLE gives only one transition.
        safe_inputs();
        start_btn = 1'b1;
        ticks(12);
        start_btn = 1'b0;
        ticks(4);
        press();

        // Gap at the bottom rows does not wrap; then floor contact.
        gap_y = 4'd12;
        bird_y = 4'd14;
        pipe_x = 4'd12;
        pass_n(3);
        bird_y = 4'd15;
        pipe_x = 4'd3;
        ticks(DEATH + 3);

        // Random play.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) start_btn = ~start_btn;
            pipe_passed = ($urandom_range(2) == 0);
            pipe_x = ($urandom_range(1) == 0) ? 4'd12 : 4'($urandom_range(15));
            gap_y = 4'($urandom_range(12));
            bird_y = 4'($urandom_range(15));
            tick();
        end

        // Saturation at 99, then hit and pass together at 07.
        start_btn = 1'b0;
        safe_inputs();
        async_reset();
        press();
        pass_n(100);
        bird_y = 4'd15;
        ticks(DEATH + 2);
        safe_inputs();
        press();
        press();
        pass_n(7);
        bird_y = 4'd0;
        gap_y = 4'd6;
        pipe_x = 4'd12;
        pipe_passed = 1'b1;
        tick();
        pipe_passed = 1'b0;
        ticks(DEATH + 2);

        // Reset mid-round clears everything without a clock edge.
        safe_inputs();
        press();
        press();
        pass_n(3);
        async_reset();
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
